// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction width, opcode field position and the
// opcode values decoded by the control unit.
package cpu_pkg;
  localparam int INSTR_W    = 32;
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OPCODE_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OPCODE_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OPCODE_SW    = 6'h2B;
  localparam logic [OPCODE_W-1:0] OPCODE_BEQ   = 6'h04;

  localparam logic [INSTR_W-1:0]  NOP_INSTR    = 32'h0;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundles.
//  imem_if : instruction memory request/response (fetch unit is master)
//    imem_req, imem_addr -> memory ; imem_rvalid, imem_rdata <- memory
//  dec_if  : fetch -> decode handshake (fetch unit is master)
//    if_valid, if_instr, if_pc, if_opcode -> decode ; id_ready <- decode
interface imem_if #(parameter int ADDR_W = 32);
  import cpu_pkg::*;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_rvalid, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_rvalid, imem_rdata);
endinterface

interface dec_if #(parameter int ADDR_W = 32);
  import cpu_pkg::*;
  logic                if_valid;
  logic                id_ready;
  logic [INSTR_W-1:0]  if_instr;
  logic [ADDR_W-1:0]   if_pc;
  logic [OPCODE_W-1:0] if_opcode;

  modport master (output if_valid, if_instr, if_pc, if_opcode, input  id_ready);
  modport slave  (input  if_valid, if_instr, if_pc, if_opcode, output id_ready);
endinterface

// File: rtl/instr_fetch_unit_buffer.sv
// fetch_buffer: DEPTH-entry synchronous FIFO of {instr, pc}.
//  push/push_instr/push_pc : enqueue
//  pop                     : dequeue head (caller guarantees non-empty)
//  flush                   : empty the FIFO, overrides push/pop
//  head_instr/head_pc      : current head entry
//  count                   : occupancy, 0..DEPTH
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  input  logic               flush,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [CW-1:0]      count
);
  logic [DEPTH-1:0][INSTR_W-1:0] instr_q;
  logic [DEPTH-1:0][ADDR_W-1:0]  pc_q;
  logic [PW-1:0]                 wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= push_instr;
        pc_q[wr_ptr]    <= push_pc;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_instr = instr_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush && !pop) |-> (count != CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (pop && !flush) |-> (count != '0));
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage. Owns the PC, issues word reads to imem under
// a credit limit, buffers in-order responses and hands them to decode.
// Redirects flush the buffer and mark every in-flight request for discard.
//  clk, rst_n                  : clock, async active-low reset
//  imem (imem_if.master)       : imem_req/imem_addr out, imem_rvalid/imem_rdata in
//  dec  (dec_if.master)        : if_valid/if_instr/if_pc/if_opcode out, id_ready in
//  redirect_valid, redirect_pc : taken branch / jump from execute
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  imem_if.master            imem,
  dec_if.master             dec,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0]  pc, resp_pc;
  logic [CW-1:0]      outstanding, drop_cnt, occ;
  logic [CW:0]        credit_used;
  logic               issue, drop_hit, push, pop;
  logic [INSTR_W-1:0] head_instr;
  logic [ADDR_W-1:0]  head_pc;

  // Outstanding requests plus buffered entries may never exceed DEPTH, so
  // every response is guaranteed a buffer slot. rst_n gates the request so
  // nothing is issued while reset is held.
  assign credit_used = {1'b0, outstanding} + {1'b0, occ};
  assign issue       = rst_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign drop_hit    = imem.imem_rvalid && (drop_cnt != '0);
  assign push        = imem.imem_rvalid && !drop_hit && !redirect_valid;
  assign pop         = dec.if_valid && dec.id_ready && !redirect_valid;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      unique case ({issue, imem.imem_rvalid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding - CW'(imem.imem_rvalid);
        pc       <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        drop_cnt <= drop_cnt - CW'(drop_hit);
        if (issue) pc      <= pc + ADDR_W'(4);
        if (push)  resp_pc <= resp_pc + ADDR_W'(4);
      end
    end
  end

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_instr (imem.imem_rdata),
    .push_pc    (resp_pc),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (occ)
  );

  // Outputs read as zero whenever nothing is presented.
  assign dec.if_valid  = (occ != '0);
  assign dec.if_instr  = dec.if_valid ? head_instr : NOP_INSTR;
  assign dec.if_pc     = dec.if_valid ? head_pc : '0;
  assign dec.if_opcode = dec.if_instr[OPCODE_MSB:OPCODE_LSB];

  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem.imem_rvalid |-> (outstanding != '0));
  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt <= outstanding);
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  imem_if #(.ADDR_W(32)) imem ();
  dec_if  #(.ADDR_W(32)) dec ();

  instr_fetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem.master),
    .dec            (dec.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit drop; } infl_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } bent_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  infl_t       infl[$];     // requests the model expects in flight, oldest first
  bent_t       mbuf[$];     // instructions the model expects buffered
  mreq_t       memq[$];     // memory model: responses scheduled for DUT requests
  logic [31:0] popped[$];   // pcs accepted by decode, for directed checks
  logic [31:0] m_pc;
  int          lat;
  int          cyc;
  int          n_total = 0;
  int          n_pass  = 0;

  logic        s_req, s_valid, s_rvalid;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [5:0]  s_opcode;

  function automatic logic [31:0] fdata(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C000000;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, got, exp);
  endtask

  // One clock cycle: entered at posedge+1, drives inputs, compares at the
  // falling edge, advances the model, returns at the next posedge+1.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy);
    bit          exp_req;
    logic [31:0] head_instr;
    infl_t       r;
    cyc++;
    redirect_valid = redir;
    redirect_pc    = rpc;
    dec.id_ready   = rdy;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem.imem_rvalid = 1'b1;
      imem.imem_rdata  = fdata(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = $urandom;
    end
    @(negedge clk);
    s_req = imem.imem_req;   s_addr = imem.imem_addr; s_rvalid = imem.imem_rvalid;
    s_valid = dec.if_valid;  s_pc = dec.if_pc;        s_instr = dec.if_instr;
    s_opcode = dec.if_opcode;

    exp_req = !redir && (infl.size() + mbuf.size() < DEPTH);
    chk("imem_req", {31'b0, s_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", s_addr, m_pc);
    chk("if_valid", {31'b0, s_valid}, {31'b0, mbuf.size() > 0});
    if (mbuf.size() > 0) begin
      head_instr = mbuf[0].instr;
      chk("if_pc", s_pc, mbuf[0].pc);
      chk("if_instr", s_instr, head_instr);
      chk("if_opcode", {26'b0, s_opcode}, {26'b0, head_instr[31:26]});
      if (rdy && !redir) popped.push_back(mbuf[0].pc);
    end

    // memory answers whatever the DUT actually asked for
    if (s_req) memq.push_back('{cyc + lat, s_addr});

    if (mbuf.size() > 0 && rdy && !redir) void'(mbuf.pop_front());
    if (s_rvalid && infl.size() > 0) begin
      r = infl.pop_front();
      if (!r.drop && !redir) mbuf.push_back('{fdata(r.addr), r.addr});
    end
    if (redir) begin
      mbuf.delete();
      foreach (infl[i]) infl[i].drop = 1'b1;
      m_pc = rpc;
    end else if (exp_req) begin
      infl.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset between edges and checks outputs fall immediately.
  task automatic do_reset(input int l);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",    {31'b0, imem.imem_req}, 32'h0);
    chk("rst_valid",  {31'b0, dec.if_valid}, 32'h0);
    chk("rst_instr",  dec.if_instr, 32'h0);
    chk("rst_pc",     dec.if_pc, 32'h0);
    chk("rst_opcode", {26'b0, dec.if_opcode}, 32'h0);
    redirect_valid = 1'b0;
    dec.id_ready = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    memq.delete(); infl.delete(); mbuf.delete(); popped.delete();
    m_pc = 32'h0;
    lat  = l;
    cyc  = 0;
    rst_n = 1'b1;
  endtask

  task automatic run_until_popped(input int n, input int budget);
    int k;
    k = 0;
    while (popped.size() < n && k < budget) begin
      cycle(1'b0, 32'h0, 1'b1);
      k++;
    end
    chk("pop_budget", {31'b0, popped.size() >= n}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    dec.id_ready = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = '0;

    // Reset release, L=1, always ready
    do_reset(1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_addr0", {31'b0, s_req} ^ s_addr, 32'h1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_addr1", s_addr, 32'h4);
    chk("t1_c2_valid", {31'b0, s_valid}, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t1_c3_valid", {31'b0, s_valid}, 32'h1);
    chk("t1_c3_pc", s_pc, 32'h0);
    chk("t1_opcode", {26'b0, s_opcode}, 32'h23);
    repeat (10) cycle(1'b0, 32'h0, 1'b1);

    // Decode stalled for 5 cycles, then drains in order
    do_reset(1);
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    chk("t2_req_stalled", {31'b0, s_req}, 32'h0);
    chk("t2_pc_frozen", s_pc, 32'h0);
    run_until_popped(3, 12);
    if (popped.size() >= 3) begin
      chk("t2_pop0", popped[0], 32'h0);
      chk("t2_pop1", popped[1], 32'h4);
      chk("t2_pop2", popped[2], 32'h8);
    end

    // L=3, redirect with two requests in flight
    do_reset(3);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h100, 1'b1);
    run_until_popped(2, 20);
    if (popped.size() >= 2) begin
      chk("t3_pop0", popped[0], 32'h100);
      chk("t3_pop1", popped[1], 32'h104);
    end

    // Redirect coinciding with a response and a decode pop
    do_reset(1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'h200, 1'b1);
    chk("t4_precond", {30'b0, s_rvalid, s_valid}, 32'h3);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_flushed", {31'b0, s_valid}, 32'h0);
    popped.delete();
    run_until_popped(1, 10);
    if (popped.size() >= 1) chk("t4_pop0", popped[0], 32'h200);

    // PC wrap
    do_reset(1);
    cycle(1'b1, 32'hFFFFFFFC, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t5_addr_top", s_addr, 32'hFFFFFFFC);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t5_addr_wrap", s_addr, 32'h0);
    popped.delete();
    run_until_popped(2, 10);
    if (popped.size() >= 2) begin
      chk("t5_pop0", popped[0], 32'hFFFFFFFC);
      chk("t5_pop1", popped[1], 32'h0);
    end

    // Randomized phases; each phase boundary is a mid-stream async reset
    for (int p = 0; p < 6; p++) begin
      do_reset(int'($urandom_range(1, 4)));
      for (int c = 0; c < 250; c++) begin
        logic [31:0] rpc;
        rpc = (($urandom % 8) == 0) ? (32'hFFFFFFF0 | (($urandom % 4) << 2))
                                    : ($urandom & 32'hFFFFFFFC);
        cycle(($urandom % 12) == 0, rpc, ($urandom % 4) != 0);
      end
    end
    do_reset(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
